// File: rtl/text_field_if.sv
// Pixel, buffer-write, cursor and font-ROM signals of the text field overlay.
// slave is the renderer side; master is whoever drives pixels and serves the ROM.
interface text_field_if #(
    parameter int N_CHARS = 16
);
    localparam int IW = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;

    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          video_on;
    logic          frame_tick;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic          cursor_en;
    logic [IW-1:0] cursor_lo;
    logic [IW-1:0] cursor_hi;
    logic [10:0]   rom_addr;
    logic [7:0]    rom_data;
    logic          blink_phase;
    logic          text_on;
    logic [11:0]   text_rgb;

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_tick,
        input  wr_en, wr_addr, wr_data,
        input  cursor_en, cursor_lo, cursor_hi,
        input  rom_data,
        output rom_addr, blink_phase, text_on, text_rgb
    );

    modport master (
        output pixel_x, pixel_y, video_on, frame_tick,
        output wr_en, wr_addr, wr_data,
        output cursor_en, cursor_lo, cursor_hi,
        output rom_data,
        input  rom_addr, blink_phase, text_on, text_rgb
    );
endinterface

// File: rtl/text_field_renderer.sv
// One-line character field overlay: buffer lookup -> font ROM -> colour, 2-clock pipeline.
// Owns the writable character buffer and the frame-tick driven cursor blink phase.
module text_field_renderer #(
    parameter int unsigned N_CHARS      = 16,
    parameter int unsigned SCALE_LOG2   = 0,
    parameter int unsigned X0           = 0,
    parameter int unsigned Y0           = 0,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] FG_RGB       = 12'hFFF,
    parameter logic [11:0] BG_RGB       = 12'h0AA,
    parameter logic [11:0] CURSOR_RGB   = 12'h000,
    parameter bit          BG_FILL      = 1'b1
) (
    input logic         clk,
    input logic         reset,
    text_field_if.slave bus
);
    localparam int unsigned IW    = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
    localparam int unsigned CW    = 8 << SCALE_LOG2;
    localparam int unsigned CH    = 16 << SCALE_LOG2;
    localparam int unsigned X_END = X0 + N_CHARS * CW;
    localparam int unsigned Y_END = Y0 + CH;
    localparam int unsigned BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [6:0]    char_buf [N_CHARS];
    logic [9:0]    rx, ry, idx_raw;
    logic [IW-1:0] idx;
    logic [2:0]    col;
    logic [3:0]    row;
    logic          in_region, cur_hit;
    logic [BW-1:0] blink_cnt;

    logic          s1_in, s1_cur;
    logic [2:0]    s1_col;
    logic          glyph;

    // Range checks use the full-width pixel value so columns left of X0 never
    // wrap into the field through the 10-bit subtraction.
    always_comb begin
        rx        = bus.pixel_x - 10'(X0);
        ry        = bus.pixel_y - 10'(Y0);
        in_region = bus.video_on
                 && (32'(bus.pixel_x) >= X0) && (32'(bus.pixel_x) < X_END)
                 && (32'(bus.pixel_y) >= Y0) && (32'(bus.pixel_y) < Y_END);
        idx_raw   = rx >> (3 + SCALE_LOG2);
        idx       = (32'(idx_raw) >= N_CHARS) ? IW'(N_CHARS - 1) : idx_raw[IW-1:0];
        col       = 3'(rx >> SCALE_LOG2);
        row       = 4'(ry >> SCALE_LOG2);
        cur_hit   = bus.cursor_en && bus.blink_phase
                 && (bus.cursor_lo <= idx) && (idx <= bus.cursor_hi);
        bus.rom_addr = in_region ? {char_buf[idx], row} : {7'h00, row};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_CHARS); i++) char_buf[i] <= 7'h00;
        end else if (bus.wr_en && (32'(bus.wr_addr) < N_CHARS)) begin
            char_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt       <= '0;
            bus.blink_phase <= 1'b0;
        end else if (bus.frame_tick) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt       <= '0;
                bus.blink_phase <= ~bus.blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Stage 1: the ROM row for this pixel arrives alongside these registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_in  <= 1'b0;
            s1_cur <= 1'b0;
            s1_col <= 3'd0;
        end else begin
            s1_in  <= in_region;
            s1_cur <= cur_hit;
            s1_col <= col;
        end
    end

    assign glyph = bus.rom_data[3'd7 - s1_col];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.text_on  <= 1'b0;
            bus.text_rgb <= 12'h000;
        end else if (!s1_in) begin
            bus.text_on  <= 1'b0;
            bus.text_rgb <= 12'h000;
        end else if (glyph) begin
            bus.text_on  <= 1'b1;
            bus.text_rgb <= FG_RGB;
        end else if (s1_cur) begin
            bus.text_on  <= 1'b1;
            bus.text_rgb <= CURSOR_RGB;
        end else begin
            bus.text_on  <= BG_FILL;
            bus.text_rgb <= BG_FILL ? BG_RGB : 12'h000;
        end
    end
endmodule

// File: doc/text_field_renderer.md
Name: text_field_renderer

Overview:
- Parametrised, pipelined character-field overlay for the VGA text path: draws one line of N_CHARS characters from an internal writable character buffer at a fixed screen origin, scaled by 2^SCALE_LOG2 (8x16 base font).
- Generates its own blink phase from frame ticks and paints a blinking cursor over a selectable character span.
- Drives the shared 1-cycle-latency font ROM. Its output is pipeline-aligned: text_on and text_rgb refer to the pixel presented 2 clocks earlier.

Parameters:
- N_CHARS, 16, characters in the field (2..64)
- SCALE_LOG2, 0, font scale; 0=8x16, 1=16x32, 2=32x64
- X0, 0, left pixel column of field
- Y0, 0, top pixel row of field
- BLINK_FRAMES, 30, frame ticks per blink half-period (>=1)
- FG_RGB, 12'hFFF, glyph pixel colour
- BG_RGB, 12'h0AA, non-glyph colour inside field
- CURSOR_RGB, 12'h000, non-glyph colour under active cursor
- BG_FILL, 1, 1: non-glyph pixels count as text_on; 0: only glyph pixels assert text_on

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- video_on  in  1  visible-area flag, aligned with pixel_x/pixel_y
- frame_tick  in  1  one-cycle pulse once per frame
- wr_en  in  1  character buffer write strobe
- wr_addr  in  IW=$clog2(N_CHARS)  character index to write
- wr_data  in  7  ASCII code
- cursor_en  in  1  enable cursor
- cursor_lo  in  IW  first cursor character index
- cursor_hi  in  IW  last cursor character index, inclusive
- rom_addr  out  11  {char_code, row} to font ROM; combinational
- rom_data  in  8  font row, valid 1 clk after rom_addr
- blink_phase  out  1  current blink phase
- text_on  out  1  pixel belongs to field; registered
- text_rgb  out  12  pixel colour; registered

Behaviour:
- Reset (async) values: all buffer entries 7'h00, blink counter 0, blink_phase 0, pipeline valid flags 0, text_on 0, text_rgb 0.
- Field geometry:
  - CW = 8<<SCALE_LOG2, CH = 16<<SCALE_LOG2.
  - in_region = video_on && X0<=pixel_x<X0+N_CHARS*CW && Y0<=pixel_y<Y0+CH.
  - rx = pixel_x-X0, ry = pixel_y-Y0, 10-bit unsigned.
  - idx = rx>>(3+SCALE_LOG2); col = (rx>>SCALE_LOG2)[2:0]; row = (ry>>SCALE_LOG2)[3:0].
- Stage 0 (combinational):
  - rom_addr = {buf[idx], row}.
  - Out of region: rom_addr = {7'h00, row}; idx is clamped so it never indexes past N_CHARS-1.
- Stage 1 (registered):
  - Stores in_region, col, and cur_hit = cursor_en && blink_phase && cursor_lo<=idx<=cursor_hi.
  - rom_data is valid in this stage; glyph = rom_data[7-col].
- Stage 2 (registered outputs):
  - !in_region: text_on=0, text_rgb=0.
  - glyph: text_on=1, text_rgb=FG_RGB.
  - cur_hit: text_on=1, text_rgb=CURSOR_RGB.
  - Otherwise: text_on=BG_FILL, text_rgb=BG_FILL ? BG_RGB : 0.
  - Total latency pixel -> output = 2 clk, constant.
- Buffer writes:
  - A write is synchronous and visible from the next clock.
  - A stage-0 read of the same index in the write cycle returns the old code.
  - wr_addr >= N_CHARS is ignored.
  - Writes are accepted regardless of video_on.
- Cursor:
  - cursor_lo > cursor_hi means an empty span: no cursor.
  - Span changes apply to the next pixel.
- Blink:
  - On frame_tick, the counter increments.
  - When counter == BLINK_FRAMES-1 and frame_tick is high: counter resets to 0 and blink_phase toggles.
  - Without frame_tick the counter holds.
  - BLINK_FRAMES=1 toggles blink_phase on every tick.
- Reset mid-frame: outputs drop to 0 immediately; the first valid output after reset release is 2 clk after the first sampled pixel.
- Pixel coordinates are wrap-free: values beyond the field are simply out of region; the subtraction must not alias pixels left of X0 into the field.

Test Plan:
- Reset released, SCALE_LOG2=0, X0=0, Y0=0, buf[0]='R' (7'h52), pixel (0,3) -> rom_addr=11'h523; ROM returns 8'hFC; 2 clk later text_on=1, text_rgb=FFF. Pixel (7,3) -> col 7 non-glyph -> text_rgb=0AA.
- SCALE_LOG2=1, X0=64: pixel (80,0) -> idx 1, col 0, row 0. Pixel (63,0) and pixel (64+N_CHARS*16,0) -> text_on=0.
- BLINK_FRAMES=3: 3 frame_ticks -> blink_phase 0->1; 6 ticks -> back to 0. Idle clocks between ticks do not change the count.
- cursor_en=1, cursor_lo=2, cursor_hi=3, blink_phase=1, non-glyph pixel in char 2 -> 000; same pixel in char 4 -> 0AA. blink_phase=0 -> 0AA.
- wr_en with wr_addr=5, data 7'h41, in the same cycle pixel idx 5 is read -> old code on rom_addr. Next cycle -> 7'h41. wr_addr=N_CHARS -> buffer unchanged.
- Assert reset with text_on=1 -> text_on=0, text_rgb=0 asynchronously; all buffer entries read back 7'h00.
